// File: rtl/axi_slv_rsp_gen_if.sv
// AXI slave response generator bus: AW/W/B/AR/R channel signals.
interface axi_slv_rsp_gen_if #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [AXI_ID_W-1:0]   awid;
    logic [7:0]            awlen;
    logic                  wvalid;
    logic                  wready;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   arid;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic                  rvalid;
    logic                  rready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output awvalid, awid, awlen, wvalid, wlast, bready,
               arvalid, arid, araddr, arlen, rready,
        input  awready, wready, bvalid, bid, bresp,
               arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awid, awlen, wvalid, wlast, bready,
               arvalid, arid, araddr, arlen, rready,
        output awready, wready, bvalid, bid, bresp,
               arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi_slv_rsp_gen.sv
// AXI slave response generator: in-order B/R responses, rdata = address pattern.
// Optional random ready backpressure via `define AXI_SLV_RSP_BP_EN.
module axi_slv_rsp_gen_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = mem[rptr[PW-1:0]];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + (PW+1)'(1);
            if (rd_en) rptr <= rptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wptr[PW-1:0]] <= din;
    end
endmodule

module axi_slv_rsp_gen #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int OSTD_NUM   = 4
) (
    input logic              aclk,
    input logic              aresetn,
    axi_slv_rsp_gen_if.slave bus
);
    localparam int BYTES = AXI_DATA_W / 8;
    localparam int SUM_W = (AXI_ADDR_W > AXI_DATA_W) ? AXI_ADDR_W : AXI_DATA_W;

    logic [2:0] bp;

`ifdef AXI_SLV_RSP_BP_EN
    logic [15:0] lfsr;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) lfsr <= 16'hACE1;
        else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign bp = lfsr[2:0];
`else
    assign bp = '1;
`endif

    logic [AXI_ID_W-1:0]   aw_id_h;
    logic [7:0]            aw_len_h;
    logic                  aw_full, aw_empty;
    logic [AXI_ID_W-1:0]   b_id_h;
    logic [1:0]            b_resp_h;
    logic                  b_full, b_empty;
    logic [AXI_ID_W-1:0]   ar_id_h;
    logic [AXI_ADDR_W-1:0] ar_addr_h;
    logic [7:0]            ar_len_h;
    logic                  ar_full, ar_empty;
    logic [7:0]            wbeat, rbeat;
    logic [1:0]            wresp;
    logic [SUM_W-1:0]      rsum;
    logic                  aw_hs, w_hs, w_done, b_hs, ar_hs, r_hs, r_done;

    assign aw_hs  = bus.awvalid && bus.awready;
    assign w_hs   = bus.wvalid && bus.wready;
    assign w_done = w_hs && bus.wlast;
    assign b_hs   = bus.bvalid && bus.bready;
    assign ar_hs  = bus.arvalid && bus.arready;
    assign r_hs   = bus.rvalid && bus.rready;
    assign r_done = r_hs && bus.rlast;
    // Early or late wlast both count as a length mismatch.
    assign wresp  = (wbeat == aw_len_h) ? 2'b00 : 2'b10;

    axi_slv_rsp_gen_fifo #(.WIDTH(AXI_ID_W + 8), .DEPTH(OSTD_NUM)) u_aw_fifo (
        .aclk(aclk), .aresetn(aresetn), .push(aw_hs), .pop(w_done),
        .din({bus.awid, bus.awlen}), .head({aw_id_h, aw_len_h}),
        .full(aw_full), .empty(aw_empty)
    );

    axi_slv_rsp_gen_fifo #(.WIDTH(AXI_ID_W + 2), .DEPTH(OSTD_NUM)) u_b_fifo (
        .aclk(aclk), .aresetn(aresetn), .push(w_done), .pop(b_hs),
        .din({aw_id_h, wresp}), .head({b_id_h, b_resp_h}),
        .full(b_full), .empty(b_empty)
    );

    axi_slv_rsp_gen_fifo #(.WIDTH(AXI_ID_W + AXI_ADDR_W + 8), .DEPTH(OSTD_NUM)) u_ar_fifo (
        .aclk(aclk), .aresetn(aresetn), .push(ar_hs), .pop(r_done),
        .din({bus.arid, bus.araddr, bus.arlen}), .head({ar_id_h, ar_addr_h, ar_len_h}),
        .full(ar_full), .empty(ar_empty)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wbeat <= '0;
            rbeat <= '0;
        end else begin
            if (w_done)    wbeat <= '0;
            else if (w_hs) wbeat <= wbeat + 8'd1;
            if (r_done)    rbeat <= '0;
            else if (r_hs) rbeat <= rbeat + 8'd1;
        end
    end

    // Readies are gated by aresetn so they drop the instant reset asserts.
    assign bus.awready = aresetn && !aw_full && bp[0];
    assign bus.wready  = aresetn && !aw_empty && !b_full && bp[1];
    assign bus.arready = aresetn && !ar_full && bp[2];

    assign bus.bvalid  = !b_empty;
    assign bus.bid     = bus.bvalid ? b_id_h : '0;
    assign bus.bresp   = bus.bvalid ? b_resp_h : '0;

    assign rsum        = SUM_W'(ar_addr_h) + SUM_W'(rbeat) * SUM_W'(BYTES);
    assign bus.rvalid  = !ar_empty;
    assign bus.rlast   = bus.rvalid && (rbeat == ar_len_h);
    assign bus.rid     = bus.rvalid ? ar_id_h : '0;
    assign bus.rdata   = bus.rvalid ? AXI_DATA_W'(rsum) : '0;
    assign bus.rresp   = 2'b00;
endmodule

// File: tb/tb_axi_slv_rsp_gen.sv
// Bench for axi_slv_rsp_gen: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_axi_slv_rsp_gen;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int OSTD   = 4;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;

    axi_slv_rsp_gen_if #(.AXI_ID_W(ID_W), .AXI_ADDR_W(ADDR_W), .AXI_DATA_W(DATA_W)) bus ();

    axi_slv_rsp_gen #(
        .AXI_ID_W(ID_W), .AXI_ADDR_W(ADDR_W), .AXI_DATA_W(DATA_W), .OSTD_NUM(OSTD)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );

    always #5 aclk = ~aclk;

    typedef struct {logic [ID_W-1:0] id; logic [7:0] len;} aw_t;
    typedef struct {logic [ID_W-1:0] id; logic [1:0] resp;} b_t;
    typedef struct {logic [ID_W-1:0] id; logic [ADDR_W-1:0] addr; logic [7:0] len;} ar_t;
    typedef struct {logic [ID_W-1:0] id; logic [DATA_W-1:0] data; logic last;} r_t;

    aw_t awq[$];
    b_t  bq[$];
    ar_t arq[$];
    int  wbeats, rbeats;
    b_t  b_log[$];
    r_t  r_log[$];
`ifdef AXI_SLV_RSP_BP_EN
    logic [15:0] m_lfsr;
`endif
    logic [2:0]        m_bp;
    logic              e_awr, e_wr, e_arr, e_bv, e_rv, e_rl;
    logic              do_aw, do_w, do_bpop, do_ar, do_r;
    logic [DATA_W-1:0] e_rdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: outstanding transactions as queues, evaluated at negedge.
    always @(negedge aclk) begin
        if (!aresetn) begin
            awq.delete(); bq.delete(); arq.delete();
            wbeats = 0;
            rbeats = 0;
`ifdef AXI_SLV_RSP_BP_EN
            m_lfsr = 16'hACE1;
`endif
            chk("rst_awready", bus.awready, 0);
            chk("rst_wready",  bus.wready,  0);
            chk("rst_arready", bus.arready, 0);
            chk("rst_bvalid",  bus.bvalid,  0);
            chk("rst_rvalid",  bus.rvalid,  0);
            chk("rst_rlast",   bus.rlast,   0);
            chk("rst_bid",     bus.bid,     0);
            chk("rst_bresp",   bus.bresp,   0);
            chk("rst_rid",     bus.rid,     0);
            chk("rst_rdata",   bus.rdata,   0);
            chk("rst_rresp",   bus.rresp,   0);
        end else begin
            m_bp = 3'b111;
`ifdef AXI_SLV_RSP_BP_EN
            m_bp = m_lfsr[2:0];
`endif
            e_awr = (awq.size() < OSTD) && m_bp[0];
            e_wr  = (awq.size() > 0) && (bq.size() < OSTD) && m_bp[1];
            e_arr = (arq.size() < OSTD) && m_bp[2];
            e_bv  = bq.size() > 0;
            e_rv  = arq.size() > 0;
            e_rl  = e_rv && (rbeats == int'(arq[0].len));
            chk("awready", bus.awready, e_awr);
            chk("wready",  bus.wready,  e_wr);
            chk("arready", bus.arready, e_arr);
            chk("bvalid",  bus.bvalid,  e_bv);
            chk("rvalid",  bus.rvalid,  e_rv);
            chk("rlast",   bus.rlast,   e_rl);
            chk("rresp",   bus.rresp,   0);
            if (e_bv) begin
                chk("bid",   bus.bid,   bq[0].id);
                chk("bresp", bus.bresp, bq[0].resp);
            end
            if (e_rv) begin
                e_rdata = DATA_W'(arq[0].addr + ADDR_W'(rbeats * (DATA_W / 8)));
                chk("rid",   bus.rid,   arq[0].id);
                chk("rdata", bus.rdata, e_rdata);
            end
            if (bus.bvalid && bus.bready) b_log.push_back('{bus.bid, bus.bresp});
            if (bus.rvalid && bus.rready) r_log.push_back('{bus.rid, bus.rdata, bus.rlast});

            do_aw   = bus.awvalid && e_awr;
            do_w    = bus.wvalid && e_wr;
            do_bpop = e_bv && bus.bready;
            do_ar   = bus.arvalid && e_arr;
            do_r    = e_rv && bus.rready;
            if (do_bpop) void'(bq.pop_front());
            if (do_w) begin
                if (bus.wlast) begin
                    bq.push_back('{awq[0].id, (wbeats == int'(awq[0].len)) ? 2'b00 : 2'b10});
                    void'(awq.pop_front());
                    wbeats = 0;
                end else begin
                    wbeats = (wbeats + 1) % 256;
                end
            end
            if (do_aw) awq.push_back('{bus.awid, bus.awlen});
            if (do_r) begin
                if (e_rl) begin
                    void'(arq.pop_front());
                    rbeats = 0;
                end else begin
                    rbeats++;
                end
            end
            if (do_ar) arq.push_back('{bus.arid, bus.araddr, bus.arlen});
`ifdef AXI_SLV_RSP_BP_EN
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_aw_t(input int id, input int len);
        logic ok = 1'b0;
        bus.awvalid = 1'b1; bus.awid = ID_W'(id); bus.awlen = 8'(len);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge aclk); ok = bus.awready;
            tick();
        end
        chk("aw_hs_timeout", ok, 1);
        bus.awvalid = 1'b0;
    endtask

    task automatic do_w_t(input logic last);
        logic ok = 1'b0;
        bus.wvalid = 1'b1; bus.wlast = last;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge aclk); ok = bus.wready;
            tick();
        end
        chk("w_hs_timeout", ok, 1);
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    task automatic do_ar_t(input int id, input int addr, input int len);
        logic ok = 1'b0;
        bus.arvalid = 1'b1; bus.arid = ID_W'(id); bus.araddr = ADDR_W'(addr); bus.arlen = 8'(len);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge aclk); ok = bus.arready;
            tick();
        end
        chk("ar_hs_timeout", ok, 1);
        bus.arvalid = 1'b0;
    endtask

    task automatic wait_b(input int n);
        for (int i = 0; i < 300 && b_log.size() < n; i++) tick();
        chk("b_wait_timeout", b_log.size() >= n, 1);
    endtask

    task automatic wait_r(input int n);
        for (int i = 0; i < 300 && r_log.size() < n; i++) tick();
        chk("r_wait_timeout", r_log.size() >= n, 1);
    endtask

    task automatic chk_b(input string nm, input int id, input int resp);
        b_t b;
        if (b_log.size() > 0) begin
            b = b_log.pop_front();
            chk({nm, "_bid"}, b.id, id);
            chk({nm, "_bresp"}, b.resp, resp);
        end
    endtask

    task automatic chk_r(input string nm, input int id, input int data, input logic last);
        r_t r;
        if (r_log.size() > 0) begin
            r = r_log.pop_front();
            chk({nm, "_rid"}, r.id, id);
            chk({nm, "_rdata"}, r.data, data);
            chk({nm, "_rlast"}, r.last, last);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.awvalid = 0; bus.awid = '0; bus.awlen = '0;
        bus.wvalid = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
        bus.rready = 0;
        repeat (3) tick();
        aresetn = 1'b1;
        tick();

        // Good burst, then early and late wlast, then a clean burst.
        bus.bready = 1'b1;
        do_aw_t(3, 3);
        for (int i = 0; i < 4; i++) do_w_t(i == 3);
        wait_b(1); chk_b("good", 3, 0);
        do_aw_t(1, 3);
        do_w_t(1'b0); do_w_t(1'b1);
        wait_b(1); chk_b("early", 1, 2);
        do_aw_t(2, 0);
        do_w_t(1'b1);
        wait_b(1); chk_b("after_err", 2, 0);
        do_aw_t(4, 0);
        do_w_t(1'b0); do_w_t(1'b1);
        wait_b(1); chk_b("late", 4, 2);

        // Single read burst.
        r_log.delete();
        bus.rready = 1'b1;
        do_ar_t(5, 'h100, 2);
        wait_r(3);
        chk_r("rd0", 5, 'h100, 0);
        chk_r("rd1", 5, 'h104, 0);
        chk_r("rd2", 5, 'h108, 1);

        // Fill the AR FIFO with rready low, then drain in order.
        r_log.delete();
        bus.rready = 1'b0;
        for (int i = 0; i < 4; i++) do_ar_t(8 + i, 'h1000 + 16 * i, 0);
        @(negedge aclk);
        chk("ar_full_arready", bus.arready, 0);
        tick();
        fork
            do_ar_t(12, 'h1040, 0);
            begin
                repeat (4) tick();
                bus.rready = 1'b1;
            end
        join
        wait_r(5);
        for (int i = 0; i < 5; i++) chk_r("order", 8 + i, 'h1000 + 16 * i, 1);

        // Reset mid-burst: outputs drop immediately, next burst restarts at beat 0.
        r_log.delete();
        do_ar_t(6, 'h200, 3);
        wait_r(1);
        #2 aresetn = 1'b0;
        #1;
        chk("async_rvalid", bus.rvalid, 0);
        chk("async_rlast",  bus.rlast,  0);
        chk("async_rdata",  bus.rdata,  0);
        chk("async_arready", bus.arready, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        tick();
        r_log.delete();
        do_ar_t(7, 'h300, 1);
        wait_r(2);
        chk_r("restart0", 7, 'h300, 0);
        chk_r("restart1", 7, 'h304, 1);

        // Randomized traffic, all outputs checked by the model each cycle.
        for (int c = 0; c < 3000; c++) begin
            bus.awvalid = ($urandom_range(0, 1) == 1);
            bus.awid    = ID_W'($urandom);
            bus.awlen   = 8'($urandom_range(0, 3));
            bus.wvalid  = ($urandom_range(0, 1) == 1);
            bus.wlast   = ($urandom_range(0, 2) == 0);
            bus.bready  = ($urandom_range(0, 3) != 0);
            bus.arvalid = ($urandom_range(0, 1) == 1);
            bus.arid    = ID_W'($urandom);
            bus.araddr  = $urandom;
            bus.arlen   = 8'($urandom_range(0, 3));
            bus.rready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        bus.bready = 1; bus.rready = 1;
        repeat (50) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
